// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART blocks: FSM state encoding, frame constants and
// the clocks-per-bit derivation.
package uart_tx_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StStart = 2'd1,
      StData  = 2'd2,
      StStop  = 2'd3
   } uart_state_e;

   localparam int unsigned DataBits = 8;
   localparam int unsigned StopBits = 1;

   localparam logic [2:0] LastDataBit = 3'(DataBits - 1);
   localparam logic [2:0] LastStopBit = 3'(StopBits - 1);

   function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                                input int unsigned baud);
      return clk_hz / baud;
   endfunction

   // Keeps the baud counter at least one bit wide when a bit lasts a single clock.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous circular FIFO buffering bytes for uart_tx. Depth must be a power of two;
// pointers wrap naturally and the occupancy count carries one extra bit.
module uart_tx_fifo #(
   parameter int unsigned Depth = 4,
   parameter int unsigned Width = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [Width-1:0] din_i,
   input  logic             pop_i,
   output logic [Width-1:0] dout_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned PtrW = $clog2(Depth);
   localparam logic [PtrW:0] DepthCnt = (PtrW + 1)'(Depth);

   logic [Width-1:0] mem_q [Depth];
   logic [Width-1:0] mem_d [Depth];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PtrW:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign full_o  = (count_q == DepthCnt);
   assign empty_o = (count_q == '0);
   assign dout_o  = mem_q[rd_ptr_q];

   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = din_i;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      unique case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/uart_tx.sv
// Memory-mapped 8N1 UART transmitter. Define UART_TX_FIFO_EN for a FIFO_DEPTH-entry
// buffer; otherwise a single holding register buffers one byte.
module uart_tx
   import uart_tx_pkg::*;
#(
   parameter int unsigned CLK_HZ     = 100000000,
   parameter int unsigned BAUD       = 115200,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic       CLK100MHZ,
   input  logic       ck_rst,
   input  logic       wr_en,
   input  logic [7:0] wr_data,
   output logic       full,
   output logic       busy,
   output logic       uart_rxd_out
);

   localparam int unsigned ClksPerBit = clks_per_bit(CLK_HZ, BAUD);
   localparam int unsigned CntW       = cnt_width(ClksPerBit);
   localparam logic [CntW-1:0] CntLast = CntW'(ClksPerBit - 1);

   uart_state_e     state_q, state_d;
   logic [CntW-1:0] baud_cnt_q, baud_cnt_d;
   logic [2:0]      bit_cnt_q, bit_cnt_d;
   logic [7:0]      shift_q, shift_d;
   logic            line_q, line_d;

   logic            push, pop;
   logic            buf_empty;
   logic [7:0]      buf_dout;
   logic            baud_wrap;

   // full is the registered status, so a pop in the same cycle cannot admit a write.
   assign push = wr_en && !full;

`ifdef UART_TX_FIFO_EN
   uart_tx_fifo #(
      .Depth (FIFO_DEPTH),
      .Width (8)
   ) u_fifo (
      .clk_i   (CLK100MHZ),
      .rst_ni  (ck_rst),
      .push_i  (push),
      .din_i   (wr_data),
      .pop_i   (pop),
      .dout_o  (buf_dout),
      .full_o  (full),
      .empty_o (buf_empty)
   );
`else
   logic [7:0] hold_q, hold_d;
   logic       hold_vld_q, hold_vld_d;
   logic       unused_fifo_depth;

   assign unused_fifo_depth = ^FIFO_DEPTH;

   always_comb begin
      hold_d     = hold_q;
      hold_vld_d = hold_vld_q;
      if (pop) begin
         hold_vld_d = 1'b0;
      end
      if (push) begin
         hold_d     = wr_data;
         hold_vld_d = 1'b1;
      end
   end

   always_ff @(posedge CLK100MHZ) begin
      if (!ck_rst) begin
         hold_q     <= '0;
         hold_vld_q <= 1'b0;
      end else begin
         hold_q     <= hold_d;
         hold_vld_q <= hold_vld_d;
      end
   end

   assign full      = hold_vld_q;
   assign buf_empty = !hold_vld_q;
   assign buf_dout  = hold_q;
`endif

   assign baud_wrap = (baud_cnt_q == CntLast);

   always_ff @(posedge CLK100MHZ) begin
      if (!ck_rst) begin
         state_q    <= StIdle;
         baud_cnt_q <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         line_q     <= 1'b1;
      end else begin
         state_q    <= state_d;
         baud_cnt_q <= baud_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         line_q     <= line_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (!buf_empty) state_d = StStart;
         StStart: if (baud_wrap) state_d = StData;
         StData:  if (baud_wrap && bit_cnt_q == LastDataBit) state_d = StStop;
         StStop: begin
            if (baud_wrap && bit_cnt_q == LastStopBit) begin
               state_d = buf_empty ? StIdle : StStart;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      pop        = 1'b0;
      baud_cnt_d = baud_wrap ? '0 : baud_cnt_q + 1'b1;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      unique case (state_q)
         StIdle: begin
            baud_cnt_d = '0;
            if (!buf_empty) begin
               pop       = 1'b1;
               shift_d   = buf_dout;
               bit_cnt_d = '0;
            end
         end
         StStart: if (baud_wrap) bit_cnt_d = '0;
         StData: begin
            if (baud_wrap) begin
               shift_d   = shift_q >> 1;
               bit_cnt_d = (bit_cnt_q == LastDataBit) ? 3'd0 : bit_cnt_q + 3'd1;
            end
         end
         StStop: begin
            if (baud_wrap) begin
               if (bit_cnt_q == LastStopBit) begin
                  bit_cnt_d = '0;
                  if (!buf_empty) begin
                     pop     = 1'b1;
                     shift_d = buf_dout;
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end
         end
         default: ;
      endcase

      // Line is registered from the next state so it changes on the same edge as the FSM.
      line_d = 1'b1;
      unique case (state_d)
         StStart: line_d = 1'b0;
         StData:  line_d = shift_d[0];
         default: line_d = 1'b1;
      endcase
   end

   assign busy         = (state_q != StIdle) || !buf_empty;
   assign uart_rxd_out = line_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at CLKS_PER_BIT=10; a serial receiver pops a byte
// scoreboard filled as writes are driven.
module tb_uart_tx;

   localparam int Cpb = 10;
`ifdef UART_TX_FIFO_EN
   localparam bit FifoEn = 1'b1;
`else
   localparam bit FifoEn = 1'b0;
`endif

   logic       clk     = 1'b0;
   logic       ck_rst  = 1'b0;
   logic       wr_en   = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic       full, busy, line;

   int total = 0;
   int bad   = 0;
   int frames = 0;
   int cyc = 0;
   int start_cyc = 0;
   int prev_start_cyc = 0;
   logic [7:0] exp_q [$];
   logic rx_abort = 1'b0;
   logic rx_busy  = 1'b0;
   logic [7:0] a5 = 8'hA5;

   uart_tx #(
      .CLK_HZ     (1000),
      .BAUD       (100),
      .FIFO_DEPTH (4)
   ) dut (
      .CLK100MHZ    (clk),
      .ck_rst       (ck_rst),
      .wr_en        (wr_en),
      .wr_data      (wr_data),
      .full         (full),
      .busy         (busy),
      .uart_rxd_out (line)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1000000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write(input logic [7:0] d, input bit acc);
      wr_en   = 1'b1;
      wr_data = d;
      tick();
      wr_en = 1'b0;
      if (acc) exp_q.push_back(d);
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while ((busy !== 1'b0 || rx_busy === 1'b1) && n < 3000) begin
         tick();
         n++;
      end
      check(tag, 32'(n < 3000), 32'd1);
   endtask

   task automatic rx_wait(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (!ck_rst) rx_abort = 1'b1;
      end
   endtask

   // Receiver: detects the first start-bit cycle and samples each bit at its centre.
   initial begin : rx
      logic [7:0] got;
      logic [7:0] want;
      got = '0;
      forever begin
         @(negedge clk);
         if (ck_rst === 1'b1 && line === 1'b0) begin
            rx_busy = 1'b1;
            rx_abort = 1'b0;
            prev_start_cyc = start_cyc;
            start_cyc = cyc;
            rx_wait(Cpb / 2);
            if (!rx_abort) check("rx_start_mid", 32'(line), 32'd0);
            for (int b = 0; b < 8; b++) begin
               rx_wait(Cpb);
               got[b] = line;
            end
            rx_wait(Cpb);
            if (!rx_abort) begin
               check("rx_stop", 32'(line), 32'd1);
               frames++;
               check("rx_frame_expected", 32'(exp_q.size() != 0), 32'd1);
               if (exp_q.size() != 0) begin
                  want = exp_q.pop_front();
                  check("rx_data", 32'(got), 32'(want));
               end
            end
            rx_busy = 1'b0;
         end
      end
   end

   initial begin
      int f0;
      int e;
      logic exp_line;
      logic line_ok;
      int n;

      // Reset held for three cycles.
      ck_rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_line", 32'(line), 32'd1);
         check("rst_busy", 32'(busy), 32'd0);
         check("rst_full", 32'(full), 32'd0);
      end
      tick();
      ck_rst = 1'b1;
      tick();

      // Single frame 0xA5, cycle-accurate line check.
      write(8'hA5, 1'b1);
      @(negedge clk);
      check("a5_pre_line", 32'(line), 32'd1);
      check("a5_busy_rise", 32'(busy), 32'd1);
      check("a5_full", 32'(full), FifoEn ? 32'd0 : 32'd1);
      for (int k = 1; k <= 100; k++) begin
         @(negedge clk);
         if (k <= 10) exp_line = 1'b0;
         else if (k <= 90) exp_line = a5[(k - 11) / 10];
         else exp_line = 1'b1;
         check("a5_line", 32'(line), 32'(exp_line));
         if (k == 100) check("a5_busy_last_stop", 32'(busy), 32'd1);
      end
      @(negedge clk);
      check("a5_busy_fall", 32'(busy), 32'd0);
      check("a5_line_idle", 32'(line), 32'd1);

      // Writes on consecutive cycles: second lands on the pop cycle.
      f0 = frames;
      write(8'h01, 1'b1);
      write(8'h80, FifoEn);
      @(negedge clk);
      check("consec_full", 32'(full), 32'd0);
      wait_idle("consec_idle");
      check("consec_frames", 32'(frames - f0), FifoEn ? 32'd2 : 32'd1);
`ifdef UART_TX_FIFO_EN
      check("consec_contig", 32'(start_cyc - prev_start_cyc), 32'd100);
`endif

      // Second write after the pop: frames must be contiguous.
      f0 = frames;
      write(8'h3C, 1'b1);
      tick();
      write(8'hC3, 1'b1);
      wait_idle("contig_idle");
      check("contig_frames", 32'(frames - f0), 32'd2);
      check("contig_gap", 32'(start_cyc - prev_start_cyc), 32'd100);

`ifdef UART_TX_FIFO_EN
      // Overfill: sixth byte dropped.
      f0 = frames;
      for (int i = 0; i < 6; i++) write(8'(16 + i), i < 5);
      @(negedge clk);
      check("fifo_full", 32'(full), 32'd1);
      wait_idle("fifo_idle");
      check("fifo_frames", 32'(frames - f0), 32'd5);
`endif

      // Hold wr_en while full across the pop cycle.
      f0 = frames;
`ifdef UART_TX_FIFO_EN
      for (int i = 0; i < 5; i++) write(8'(8'h20 + i), 1'b1);
`else
      write(8'h20, 1'b1);
      tick();
      write(8'h21, 1'b1);
`endif
      @(negedge clk);
      check("hold_full_before", 32'(full), 32'd1);
      wr_en   = 1'b1;
      wr_data = 8'hEE;
      n = 0;
      do begin
         tick();
         n++;
      end while (full === 1'b1 && n < 200);
      wr_en = 1'b0;
      check("hold_full_release", 32'(n < 200), 32'd1);
      write(8'h5A, 1'b1);
      @(negedge clk);
      check("hold_count_dec_one", 32'(full), 32'd1);
      wait_idle("hold_idle");
      check("hold_frames", 32'(frames - f0), FifoEn ? 32'd6 : 32'd3);

      // Reset during data bit 3 with bytes buffered.
      write(8'h96, 1'b1);
      e = cyc;
      tick();
      write(8'h69, 1'b1);
`ifdef UART_TX_FIFO_EN
      write(8'h77, 1'b1);
`endif
      while (cyc < e + 44) tick();
      check("rst_mid_bit3", 32'(line), 32'd0);
      ck_rst = 1'b0;
      tick();
      @(negedge clk);
      check("rst_mid_line", 32'(line), 32'd1);
      check("rst_mid_busy", 32'(busy), 32'd0);
      check("rst_mid_full", 32'(full), 32'd0);
      ck_rst = 1'b1;
      exp_q.delete();
      f0 = frames;
      line_ok = 1'b1;
      for (int i = 0; i < 250; i++) begin
         tick();
         if (line !== 1'b1 || busy !== 1'b0) line_ok = 1'b0;
      end
      check("rst_after_quiet", 32'(line_ok), 32'd1);
      check("rst_after_frames", 32'(frames - f0), 32'd0);

      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
